// File: rtl/pe_op_sequencer.sv
// pe_op_sequencer: drives one PE through weight-stationary or output-stationary
// passes of K operands and collects its results into a small valid/ready FIFO.
module pe_op_sequencer #(
  parameter int ACT_WIDTH    = 8,
  parameter int WGT_WIDTH    = 8,
  parameter int PE_OUT_WIDTH = 32,
  parameter int LEN_WIDTH    = 8,
  parameter int RES_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  // command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_mode,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [WGT_WIDTH-1:0]    cmd_wgt,
  // operand stream
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [ACT_WIDTH-1:0]    op_act,
  input  logic [WGT_WIDTH-1:0]    op_wgt,
  input  logic [PE_OUT_WIDTH-1:0] op_psum,
  // PE side
  output logic [2:0]              pe_op,
  output logic [ACT_WIDTH-1:0]    pe_act,
  output logic [WGT_WIDTH-1:0]    pe_wgt,
  output logic [PE_OUT_WIDTH-1:0] pe_psum,
  output logic                    pe_acc_clr,
  input  logic [PE_OUT_WIDTH-1:0] pe_result,
  // results
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [PE_OUT_WIDTH-1:0] res_data,
  output logic                    res_last
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] W_FLOW   = 3'b000;
  localparam logic [2:0] W_LOAD   = 3'b001;
  localparam logic [2:0] OS_FLOW  = 3'b100;
  localparam logic [2:0] OS_DRAIN = 3'b110;

  typedef enum logic [2:0] {IDLE, WLOAD, WFLOW, OCLR, OACC, ODRAIN} state_t;

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
    logic [WGT_WIDTH-1:0] wgt;
  } cmd_t;

  typedef struct packed {
    logic [PE_OUT_WIDTH-1:0] data;
    logic                    last;
  } res_t;

  state_t               state;
  cmd_t                 cmd_q;
  logic [LEN_WIDTH-1:0] fire_cnt;
  logic                 infl_vld, infl_last;

  res_t                 fifo_mem [RES_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_cnt;

  logic fire, last_fire, fifo_full, fifo_empty, pop, push, drain_push, ws_room;
  res_t push_ent, head;

  assign fire       = op_valid && op_ready;
  assign last_fire  = fire && (fire_cnt == cmd_q.len - LEN_WIDTH'(1));
  assign fifo_full  = (fifo_cnt == CW'(RES_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = res_valid && res_ready;
  // a full FIFO can still take the drain result if the head leaves this cycle
  assign drain_push = (state == ODRAIN) && (!fifo_full || pop);
  assign push       = infl_vld || drain_push;
  // reserve a slot for the result already in the PE so a WS capture never overflows
  assign ws_room    = (fifo_cnt + CW'(infl_vld)) < CW'(RES_DEPTH);

  assign push_ent.data = pe_result;
  assign push_ent.last = infl_vld ? infl_last : 1'b1;

  assign cmd_ready  = reset_n && (state == IDLE);

  assign head       = fifo_mem[rd_ptr];
  assign res_valid  = !fifo_empty;
  assign res_data   = res_valid ? head.data : '0;
  assign res_last   = res_valid ? head.last : 1'b0;

  // PE drive and operand ready, decoded from state and the operand handshake
  always_comb begin
    pe_op      = W_FLOW;
    pe_act     = '0;
    pe_wgt     = '0;
    pe_psum    = '0;
    pe_acc_clr = 1'b0;
    op_ready   = 1'b0;
    case (state)
      WLOAD: begin
        pe_op  = W_LOAD;
        pe_wgt = cmd_q.wgt;
      end
      WFLOW: begin
        op_ready = ws_room;
        if (op_valid && ws_room) begin
          pe_act  = op_act;
          pe_psum = op_psum;
        end
      end
      OCLR: begin
        pe_op      = OS_FLOW;
        pe_acc_clr = 1'b1;
      end
      OACC: begin
        pe_op    = OS_FLOW;
        op_ready = 1'b1;
        if (op_valid) begin
          pe_act = op_act;
          pe_wgt = op_wgt;
        end
      end
      ODRAIN: pe_op = OS_DRAIN;
      default: ;
    endcase
  end

  // pass sequencing: command latch, operand count, state transitions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      fire_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // zero-length commands are accepted and dropped without leaving IDLE
          if (cmd_valid && cmd_len != '0) begin
            cmd_q.len <= cmd_len;
            cmd_q.wgt <= cmd_wgt;
            fire_cnt  <= '0;
            state     <= cmd_mode ? OCLR : WLOAD;
          end
        end
        WLOAD: state <= WFLOW;
        WFLOW: begin
          if (fire) fire_cnt <= fire_cnt + LEN_WIDTH'(1);
          if (last_fire) state <= IDLE;
        end
        OCLR: state <= OACC;
        OACC: begin
          if (fire) fire_cnt <= fire_cnt + LEN_WIDTH'(1);
          if (last_fire) state <= ODRAIN;
        end
        ODRAIN: if (drain_push) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // WS result appears on pe_result one cycle after its operand fires
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      infl_vld  <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      infl_vld  <= (state == WFLOW) && fire;
      infl_last <= (state == WFLOW) && last_fire;
    end
  end

  // FIFO pointers and occupancy; reset flushes everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; outputs are masked while empty so no reset is needed here
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_ent;
  end

endmodule

// File: tb/tb_pe_op_sequencer.sv
// tb_pe_op_sequencer: closes the loop with a behavioural PE, scores results
// against expectations computed from the command and its operands.
module tb_pe_op_sequencer;
  localparam int AW = 8, WW = 8, PW = 32, LW = 8, RD = 4;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_mode = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic [WW-1:0] cmd_wgt = '0;
  logic          op_valid = 1'b0, op_ready;
  logic [AW-1:0] op_act = '0;
  logic [WW-1:0] op_wgt = '0;
  logic [PW-1:0] op_psum = '0;
  logic [2:0]    pe_op;
  logic [AW-1:0] pe_act;
  logic [WW-1:0] pe_wgt;
  logic [PW-1:0] pe_psum, pe_result, res_data;
  logic          pe_acc_clr, res_valid, res_ready = 1'b0, res_last;

  always #5 clk = ~clk;

  pe_op_sequencer #(.ACT_WIDTH(AW), .WGT_WIDTH(WW), .PE_OUT_WIDTH(PW),
                    .LEN_WIDTH(LW), .RES_DEPTH(RD)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_len(cmd_len), .cmd_wgt(cmd_wgt),
    .op_valid(op_valid), .op_ready(op_ready), .op_act(op_act),
    .op_wgt(op_wgt), .op_psum(op_psum),
    .pe_op(pe_op), .pe_act(pe_act), .pe_wgt(pe_wgt), .pe_psum(pe_psum),
    .pe_acc_clr(pe_acc_clr), .pe_result(pe_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last));

  // behavioural PE: WS multiplies by a loaded weight, OS accumulates
  logic [PW-1:0] pe_w, pe_acc, pe_res;
  assign pe_result = pe_res;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_w <= '0; pe_acc <= '0; pe_res <= '0;
    end else if (pe_acc_clr) begin
      pe_acc <= '0; pe_res <= '0;
    end else begin
      case (pe_op)
        3'b001: pe_w <= PW'(pe_wgt);
        3'b000: pe_res <= pe_psum + PW'(pe_act) * pe_w;
        3'b100: begin
          pe_acc <= pe_acc + PW'(pe_act) * PW'(pe_wgt);
          pe_res <= pe_acc + PW'(pe_act) * PW'(pe_wgt);
        end
        default: ;
      endcase
    end
  end

  typedef struct packed {logic [PW-1:0] data; logic last;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int total = 0, bad = 0, fires = 0, rr_mode = 1;
  logic [AW-1:0] op_a [16];
  logic [WW-1:0] op_w [16];
  logic [PW-1:0] op_p [16];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++; bad++;
    $display("FAIL %s", nm);
  endtask

  // monitor: every accepted result is popped against the scoreboard
  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: got %0h expected none", res_data);
      end else begin
        mon_e = sb.pop_front();
        chk("res_data", 64'(res_data), 64'(mon_e.data));
        chk("res_last", 64'(res_last), 64'(mon_e.last));
      end
    end
  end

  // result sink: 0 = hold off, 1 = always ready, else random
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0: res_ready = 1'b0;
      1: res_ready = 1'b1;
      default: res_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic send_cmd(input logic m, input logic [LW-1:0] len, input logic [WW-1:0] w);
    int t = 0;
    cmd_valid = 1'b1; cmd_mode = m; cmd_len = len; cmd_wgt = w;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 200);
    if (!cmd_ready) fail("cmd_timeout");
    @(posedge clk); #1 cmd_valid = 1'b0;
    if (len != 0) begin
      @(negedge clk);
      if (!m) begin
        chk("wload_op", 64'(pe_op), 64'(3'b001));
        chk("wload_wgt", 64'(pe_wgt), 64'(w));
      end else begin
        chk("oclr_clr", 64'(pe_acc_clr), 64'(1));
        chk("oclr_op", 64'(pe_op), 64'(3'b100));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_op(input logic m, input logic [AW-1:0] a, input logic [WW-1:0] w,
                         input logic [PW-1:0] p, input int gap);
    int t = 0;
    op_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      chk("bubble_act", 64'(pe_act), 64'(0));
      if (m) chk("bubble_wgt", 64'(pe_wgt), 64'(0));
      else   chk("bubble_psum", 64'(pe_psum), 64'(0));
      @(posedge clk); #1;
    end
    op_valid = 1'b1; op_act = a; op_wgt = w; op_psum = p;
    do begin @(negedge clk); t++; end while (!op_ready && t < 200);
    if (!op_ready) fail("op_timeout");
    else begin
      chk("fire_op", 64'(pe_op), m ? 64'(3'b100) : 64'(3'b000));
      chk("fire_act", 64'(pe_act), 64'(a));
      if (m) chk("fire_wgt", 64'(pe_wgt), 64'(w));
      else   chk("fire_psum", 64'(pe_psum), 64'(p));
      chk("fire_clr", 64'(pe_acc_clr), 64'(0));
      fires++;
    end
    @(posedge clk); #1 op_valid = 1'b0;
  endtask

  // expected results come straight from the pass definition
  task automatic run_cmd(input logic m, input int len, input logic [WW-1:0] w, input int gap);
    exp_t e;
    logic [PW-1:0] sum = '0;
    for (int i = 0; i < len; i++) begin
      if (!m) begin
        e.data = op_p[i] + PW'(op_a[i]) * PW'(w);
        e.last = (i == len - 1);
        sb.push_back(e);
      end else sum += PW'(op_a[i]) * PW'(op_w[i]);
    end
    if (m && len != 0) begin e.data = sum; e.last = 1'b1; sb.push_back(e); end
    send_cmd(m, LW'(len), w);
    for (int i = 0; i < len; i++)
      send_op(m, op_a[i], op_w[i], op_p[i], gap < 0 ? $urandom_range(0, 2) : gap);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    if (sb.size() != 0) fail("drain_timeout");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_op_ready", 64'(op_ready), 64'(0));
    chk("rst_pe_op", 64'(pe_op), 64'(0));
    chk("rst_pe_data", 64'({pe_act, pe_wgt, pe_acc_clr}), 64'(0));
    chk("rst_pe_psum", 64'(pe_psum), 64'(0));
    chk("rst_res", 64'({res_valid, res_last}), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    // WS, weight 3: (1,0) (3,11) (6,3) -> 3, 20, 21
    op_a[0] = 1; op_p[0] = 0; op_a[1] = 3; op_p[1] = 11; op_a[2] = 6; op_p[2] = 3;
    for (int i = 0; i < 3; i++) op_w[i] = 8'hAA;
    run_cmd(1'b0, 3, 8'd3, 0);
    wait_drain();

    // OS K=2 (10,10) x2 -> 200, drain cycle and latency
    for (int i = 0; i < 2; i++) begin op_a[i] = 10; op_w[i] = 10; op_p[i] = 32'h55; end
    run_cmd(1'b1, 2, 8'd0, 0);
    @(negedge clk);
    chk("drain_op", 64'(pe_op), 64'(3'b110));
    chk("drain_res_valid", 64'(res_valid), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("os_res_valid", 64'(res_valid), 64'(1));
    wait_drain();

    // backpressure: FIFO of 4 fills, op_ready drops after 4 fires
    rr_mode = 0; fires = 0;
    for (int i = 0; i < 6; i++) begin op_a[i] = AW'(i); op_w[i] = 0; op_p[i] = 0; end
    fork
      run_cmd(1'b0, 6, 8'd2, 0);
      begin
        repeat (20) @(negedge clk);
        chk("bp_fires", 64'(fires), 64'(4));
        chk("bp_op_ready", 64'(op_ready), 64'(0));
        rr_mode = 1;
      end
    join
    wait_drain();

    // bubbles: OS K=3 with a gap before each operand -> 44
    op_a[0] = 1; op_w[0] = 2; op_a[1] = 3; op_w[1] = 4; op_a[2] = 5; op_w[2] = 6;
    run_cmd(1'b1, 3, 8'd0, 1);
    wait_drain();

    // zero-length command is consumed and dropped
    send_cmd(1'b0, '0, 8'd5);
    @(negedge clk);
    chk("len0_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("len0_pe_op", 64'(pe_op), 64'(0));
    chk("len0_op_ready", 64'(op_ready), 64'(0));
    @(posedge clk); #1;

    // back-to-back WS then OS across the WS capture cycle
    rr_mode = 2;
    op_a[0] = 1; op_w[0] = 0; op_p[0] = 0;
    run_cmd(1'b0, 1, 8'd3, 0);
    for (int i = 0; i < 2; i++) begin op_a[i] = 10; op_w[i] = 10; op_p[i] = 0; end
    run_cmd(1'b1, 2, 8'd0, 0);
    wait_drain();

    // reset during OACC after 1 of 3 operands: nothing escapes
    send_cmd(1'b1, 8'd3, 8'd0);
    send_op(1'b1, 8'd4, 8'd5, 32'd0, 0);
    op_valid = 1'b1;
    reset_n = 1'b0;
    #2;
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("mid_rst_op_ready", 64'(op_ready), 64'(0));
    chk("mid_rst_pe_op", 64'(pe_op), 64'(0));
    chk("mid_rst_pe_data", 64'({pe_act, pe_wgt, pe_acc_clr}), 64'(0));
    chk("mid_rst_res_valid", 64'(res_valid), 64'(0));
    op_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_res_valid", 64'(res_valid), 64'(0));
    end
    @(posedge clk); #1;
    op_a[0] = 7; op_w[0] = 7; op_p[0] = 0;
    run_cmd(1'b1, 1, 8'd0, 0);
    wait_drain();

    // randomized mix of commands
    for (int n = 0; n < 40; n++) begin
      int len = $urandom_range(0, 6);
      logic m = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        op_a[i] = AW'($urandom); op_w[i] = WW'($urandom); op_p[i] = $urandom;
      end
      run_cmd(m, len, WW'($urandom), -1);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    wait_drain();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_op_sequencer.md
# pe_op_sequencer

Initiator side of the PE operation interface. It accepts a command (weight-stationary or output-stationary pass of K operands) and a valid/ready operand stream, and drives a single `pe` with the correct `operation_signal` sequence, operands and accumulator clears. It collects `result_out` into a small result FIFO with valid/ready output. It sits between the operand buffers and one PE (or a column head) in the systolic datapath.

## Interface
- `ACT_WIDTH`, 8, activation width
- `WGT_WIDTH`, 8, weight width
- `PE_OUT_WIDTH`, 32, psum/result width
- `LEN_WIDTH`, 8, width of operand count K
- `RES_DEPTH`, 4, result FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_mode`  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS)
- `cmd_len`  in  LEN_WIDTH  operand count K
- `cmd_wgt`  in  WGT_WIDTH  stationary weight (WS only)
- `op_valid` / `op_ready`  in / out  1  operand handshake
- `op_act`  in  ACT_WIDTH  activation
- `op_wgt`  in  WGT_WIDTH  weight (OS only)
- `op_psum`  in  PE_OUT_WIDTH  incoming psum (WS only)
- `pe_op`  out  3  to PE `operation_signal_in`
- `pe_act`, `pe_wgt`, `pe_psum`  out  ACT/WGT/PE_OUT_WIDTH  to PE `act_data_in`, `wgt_data_in`, `result_in`
- `pe_acc_clr`  out  1  to PE active-high `reset`
- `pe_result`  in  PE_OUT_WIDTH  from PE `result_out`
- `res_valid` / `res_ready`  out / in  1  result handshake
- `res_data`  out  PE_OUT_WIDTH  result
- `res_last`  out  1  final result of the command

## Operation
- Op codes:
  - `W_FLOW` = 000
  - `W_LOAD` = 001
  - `OS_FLOW` = 100
  - `OS_DRAIN` = 110
- `pe_*` outputs are combinational from the state register and the operand handshake. Captured data, counters and FIFO are registered.
- States: IDLE, WLOAD, WFLOW, OCLR, OACC, ODRAIN.
- IDLE:
  - `pe_op`=000, all `pe_*` data = 0.
  - On `cmd_valid` with `cmd_len`≠0: latch mode, K and weight. WS goes to WLOAD; OS goes to OCLR.
  - A command with `cmd_len`=0 is consumed and dropped. State stays IDLE and no result is produced.
- WLOAD (1 cycle): `pe_op`=001, `pe_wgt`=latched weight, then go to WFLOW.
- WFLOW: `pe_op`=000.
  - On a fire (`op_valid && op_ready`): `pe_act`=`op_act`, `pe_psum`=`op_psum`.
  - Otherwise `pe_act`=0, `pe_psum`=0, and the PE output is discarded.
  - Each fire schedules capture of `pe_result` in the next cycle.
  - After the K-th fire, go to IDLE. `res_last` is tagged on the K-th result.
- OCLR (1 cycle): `pe_acc_clr`=1, `pe_op`=100, data 0, then go to OACC.
- OACC: `pe_op`=100.
  - On a fire: `pe_act`=`op_act`, `pe_wgt`=`op_wgt`.
  - Bubbles drive act=wgt=0, so the PE accumulator is unchanged.
  - After the K-th fire, go to ODRAIN.
- ODRAIN: `pe_op`=110.
  - `pe_result` holds the accumulated sum in this cycle.
  - It is pushed to the FIFO with `res_last`=1 when a slot is free; the block stays in ODRAIN while the FIFO is full. Then go to IDLE.
- `op_ready` is high in WFLOW/OACC only, and only when `fifo_count + inflight < RES_DEPTH` (WS); in OS it is gated by state alone.
- Result FIFO:
  - Push and pop in the same cycle when full is legal; the count is unchanged.
  - `res_data`/`res_last` come from the head entry.
  - Order is preserved and there is no overflow.
- Arithmetic belongs to the PE. This block never modifies data widths beyond zero bubbles.

## Timing
- Reset values:
  - `cmd_ready`=0 while `reset_n`=0, then 1 in the first IDLE cycle.
  - `op_ready`=0, `pe_op`=000, `pe_act`/`pe_wgt`/`pe_psum`=0, `pe_acc_clr`=0.
  - `res_valid`=0, `res_data`=0, `res_last`=0.
  - FIFO empty, inflight cleared.
- WS latency: an operand fired in cycle n appears on `pe_result` in n+1, is captured at the end of n+1, and `res_valid` is high in n+2 with an empty FIFO.
- OS latency: cmd accept at n, OCLR at n+1, first OACC at n+2. With continuous operands, ODRAIN is at n+2+K and `res_valid` is at n+3+K.
- WS peak throughput is 1 operand/cycle. The WS pass length is K+1 cycles, or more if `op_valid` stalls.
- Reset asserted mid-command:
  - The pass is aborted immediately and the FIFO flushed.
  - In-flight results are discarded; no partial result is ever emitted.
- A new command is accepted in the IDLE cycle that still captures the last WS in-flight result; the capture must not be lost.

## Test plan
- WS, `cmd_wgt`=3, K=3, operands (act,psum) = (1,0), (3,11), (6,3) → results 3, 20, 21; `res_last` only on 21; `pe_op` sequence 001, 000, 000, 000.
- OS, K=2, operands (10,10) twice → exactly one result, 200, with `res_last`=1. `pe_acc_clr` pulses exactly one cycle before the first 100, and `pe_op`=110 appears in the drain cycle.
- Backpressure: `res_ready`=0, WS K=6 with weight 2 and act=i, psum=0 → `op_ready` drops after 4 fires. Releasing `res_ready` gives 0, 2, 4, 6, 8, 10 in order with no loss.
- Bubbles: OS K=3 with `op_valid` toggling every other cycle and operands (1,2), (3,4), (5,6) → result 44; bubble cycles show act=wgt=0.
- `cmd_len`=0 → consumed in 1 cycle, no `pe_op` activity, no result. Back-to-back WS then OS → results 3, then 200, with nothing dropped at the boundary.
- `reset_n` pulsed low during OACC after 1 of 3 operands → outputs return to reset values, `res_valid` stays 0, and the next OS K=1 with (7,7) → 49.
